// File: rtl/wb_stage.sv
// Writeback stage feeding the register file.
// Takes one retiring instruction per cycle from MEM. Loads wait for dmem
// read data, which is aligned and extended before it is written back.
// Counts retired instructions and keeps sticky flags for misaligned loads
// and load timeouts.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   in_valid/in_ready handshake from MEM (transfer = in_valid & in_ready)
//   in_waddr, in_we   destination register and its write flag
//   in_result         ALU result (not used for loads)
//   in_load, in_ltype load flag and type (0 LB,1 LBU,2 LH,3 LHU,4 LW)
//   in_addr_lo        load address bits [1:0]
//   dmem_rvalid/rdata load return (one-cycle pulse, little-endian word)
//   waddr/wdata/we    registered regfile write port
//   retire_cnt        wrapping count of retired instructions
//   err_misalign      sticky: misaligned or reserved-type load seen
//   err_timeout       sticky: load dropped after TIMEOUT cycles
module wb_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_waddr,
  input  logic             in_we,
  input  logic [31:0]      in_result,
  input  logic             in_load,
  input  logic [2:0]       in_ltype,
  input  logic [1:0]       in_addr_lo,
  input  logic             dmem_rvalid,
  input  logic [31:0]      dmem_rdata,
  output logic [4:0]       waddr,
  output logic [31:0]      wdata,
  output logic             we,
  output logic [CNT_W-1:0] retire_cnt,
  output logic             err_misalign,
  output logic             err_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {EMPTY, WAIT, WRITE} state_t;

  state_t      state, state_d;
  logic [TW-1:0] timer, timer_d;
  logic [2:0]  ld_type, ld_type_d;
  logic [1:0]  ld_lo, ld_lo_d;
  logic        ld_we, ld_we_d;
  logic [4:0]  waddr_d;
  logic [31:0] wdata_d;
  logic        we_d, mis_d, tmo_d;

  logic        xfer, bad;
  logic [31:0] shifted, aligned;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  assign in_ready = (state != WAIT);
  assign xfer     = in_valid & in_ready;

  // Reserved types and halfword/word loads off their natural boundary are
  // rejected at accept; they retire without touching the register file.
  assign bad = (in_ltype > 3'd4)
             | (((in_ltype == 3'd2) | (in_ltype == 3'd3)) & in_addr_lo[0])
             | ((in_ltype == 3'd4) & (in_addr_lo != 2'd0));

  assign shifted = dmem_rdata >> {ld_lo, 3'b000};
  assign lbyte   = shifted[7:0];
  assign lhalf   = ld_lo[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    case (ld_type)
      3'd0:    aligned = {{24{lbyte[7]}}, lbyte};
      3'd1:    aligned = {24'b0, lbyte};
      3'd2:    aligned = {{16{lhalf[15]}}, lhalf};
      3'd3:    aligned = {16'b0, lhalf};
      default: aligned = dmem_rdata;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_d;
  end

  // next state
  always_comb begin
    state_d = state;
    case (state)
      WAIT: begin
        // rvalid on the expiry cycle still counts as a good return
        if (dmem_rvalid || timer == TMAX) state_d = WRITE;
      end
      default: begin
        if (xfer) state_d = (in_load && !bad) ? WAIT : WRITE;
        else      state_d = EMPTY;
      end
    endcase
  end

  // outputs / datapath next values
  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr;
    wdata_d   = wdata;
    timer_d   = timer;
    mis_d     = err_misalign;
    tmo_d     = err_timeout;
    ld_type_d = ld_type;
    ld_lo_d   = ld_lo;
    ld_we_d   = ld_we;
    case (state)
      WAIT: begin
        if (dmem_rvalid) begin
          wdata_d = aligned;
          we_d    = ld_we & (waddr != 5'd0);
        end else if (timer == TMAX) begin
          tmo_d   = 1'b1;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        if (xfer) begin
          waddr_d   = in_waddr;
          ld_type_d = in_ltype;
          ld_lo_d   = in_addr_lo;
          ld_we_d   = in_we;
          if (!in_load) begin
            wdata_d = in_result;
            we_d    = in_we & (in_waddr != 5'd0);
          end else if (bad) begin
            mis_d   = 1'b1;
          end else begin
            timer_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we           <= 1'b0;
      waddr        <= '0;
      wdata        <= '0;
      timer        <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
      ld_type      <= '0;
      ld_lo        <= '0;
      ld_we        <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      we           <= we_d;
      waddr        <= waddr_d;
      wdata        <= wdata_d;
      timer        <= timer_d;
      err_misalign <= mis_d;
      err_timeout  <= tmo_d;
      ld_type      <= ld_type_d;
      ld_lo        <= ld_lo_d;
      ld_we        <= ld_we_d;
      // every cycle spent in WRITE is one retired instruction
      if (state == WRITE) retire_cnt <= retire_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_we, in_load, dmem_rvalid;
  logic [4:0]       in_waddr, waddr;
  logic [31:0]      in_result, dmem_rdata, wdata;
  logic [2:0]       in_ltype;
  logic [1:0]       in_addr_lo;
  logic             we, err_misalign, err_timeout;
  logic [CNT_W-1:0] retire_cnt;

  int n_chk = 0;
  int n_err = 0;
  int exp_cnt = 0;

  wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_waddr(in_waddr), .in_we(in_we), .in_result(in_result),
    .in_load(in_load), .in_ltype(in_ltype), .in_addr_lo(in_addr_lo),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .waddr(waddr), .wdata(wdata), .we(we),
    .retire_cnt(retire_cnt),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    logic [CNT_W-1:0] e;
    e = CNT_W'(exp_cnt);
    chk(tag, 32'(retire_cnt), 32'(e));
  endtask

  task automatic alu(input logic [4:0] ra, input logic [31:0] val);
    in_valid = 1'b1; in_load = 1'b0; in_we = 1'b1;
    in_waddr = ra; in_result = val;
  endtask

  // Issue a load, hold WAIT for dly cycles, then return rd and check the write.
  task automatic do_load(input string tag, input logic [2:0] lt, input logic [1:0] lo,
                         input logic [4:0] ra, input logic [31:0] rd, input int dly,
                         input logic [31:0] exp);
    in_valid = 1'b1; in_load = 1'b1; in_we = 1'b1; in_waddr = ra;
    in_ltype = lt; in_addr_lo = lo; in_result = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0; in_load = 1'b0;
    chk({tag, " ready_wait"}, 32'(in_ready), 32'd0);
    chk({tag, " we_wait"}, 32'(we), 32'd0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk({tag, " ready_hold"}, 32'(in_ready), 32'd0);
      chk({tag, " we_hold"}, 32'(we), 32'd0);
    end
    dmem_rvalid = 1'b1; dmem_rdata = rd;
    tick();
    dmem_rvalid = 1'b0;
    chk({tag, " we"}, 32'(we), 32'd1);
    chk({tag, " waddr"}, 32'(waddr), 32'(ra));
    chk({tag, " wdata"}, wdata, exp);
    chk({tag, " ready_wr"}, 32'(in_ready), 32'd1);
    tick();
    exp_cnt++;
    chk({tag, " we_off"}, 32'(we), 32'd0);
    chk_cnt({tag, " cnt"});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_we = 1'b0; in_load = 1'b0;
    in_waddr = '0; in_result = '0; in_ltype = '0; in_addr_lo = '0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    #12;
    chk("rst we", 32'(we), 32'd0);
    chk("rst waddr", 32'(waddr), 32'd0);
    chk("rst wdata", wdata, 32'd0);
    chk_cnt("rst cnt");
    chk("rst ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // 1: back-to-back ALU writes
    alu(5'd3, 32'h11);
    tick();
    chk("alu0 we", 32'(we), 32'd1);
    chk("alu0 waddr", 32'(waddr), 32'd3);
    chk("alu0 wdata", wdata, 32'h11);
    chk("alu0 ready", 32'(in_ready), 32'd1);
    alu(5'd4, 32'h22);
    tick();
    in_valid = 1'b0;
    chk("alu1 we", 32'(we), 32'd1);
    chk("alu1 waddr", 32'(waddr), 32'd4);
    chk("alu1 wdata", wdata, 32'h22);
    tick();
    exp_cnt = 2;
    chk("alu idle we", 32'(we), 32'd0);
    chk("alu idle wdata", wdata, 32'h22);
    chk_cnt("alu cnt");

    // 2: alignment / extension
    do_load("lb",  3'd0, 2'd3, 5'd6, 32'h80FF7F01, 0, 32'hFFFFFF80);
    do_load("lbu", 3'd1, 2'd2, 5'd7, 32'h80FF7F01, 1, 32'h000000FF);
    do_load("lh",  3'd2, 2'd2, 5'd8, 32'h80FF7F01, 0, 32'hFFFF80FF);
    do_load("lhu", 3'd3, 2'd0, 5'd9, 32'h80FF7F01, 0, 32'h00007F01);
    do_load("lw",  3'd4, 2'd0, 5'd10, 32'h80FF7F01, 0, 32'h80FF7F01);

    // 3: load to r5 returning later; then rvalid on the last allowed cycle
    do_load("ld5", 3'd4, 2'd0, 5'd5, 32'h1234_5678, 2, 32'h1234_5678);
    do_load("ldedge", 3'd1, 2'd1, 5'd11, 32'h0000_AB00, 3, 32'h0000_00AB);
    chk("edge no tmo", 32'(err_timeout), 32'd0);

    // 4: timeout after TIMEOUT WAIT cycles
    in_valid = 1'b1; in_load = 1'b1; in_we = 1'b1; in_waddr = 5'd12;
    in_ltype = 3'd4; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0; in_load = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    chk("tmo pre flag", 32'(err_timeout), 32'd0);
    chk("tmo pre ready", 32'(in_ready), 32'd0);
    tick();
    chk("tmo flag", 32'(err_timeout), 32'd1);
    chk("tmo we", 32'(we), 32'd0);
    chk("tmo ready", 32'(in_ready), 32'd1);
    tick();
    exp_cnt++;
    chk_cnt("tmo cnt");
    dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick();
    dmem_rvalid = 1'b0;
    chk("late rvalid we", 32'(we), 32'd0);
    chk_cnt("late rvalid cnt");

    // 5: misaligned LW, then write to r0
    in_valid = 1'b1; in_load = 1'b1; in_we = 1'b1; in_waddr = 5'd13;
    in_ltype = 3'd4; in_addr_lo = 2'd2;
    tick();
    in_valid = 1'b0; in_load = 1'b0;
    chk("mis flag", 32'(err_misalign), 32'd1);
    chk("mis we", 32'(we), 32'd0);
    chk("mis ready", 32'(in_ready), 32'd1);
    tick();
    exp_cnt++;
    chk_cnt("mis cnt");
    alu(5'd0, 32'h55);
    tick();
    in_valid = 1'b0;
    chk("r0 we", 32'(we), 32'd0);
    tick();
    exp_cnt++;
    chk_cnt("r0 cnt");

    // 6: async reset mid-WAIT, then counter wrap
    in_valid = 1'b1; in_load = 1'b1; in_we = 1'b1; in_waddr = 5'd14;
    in_ltype = 3'd4; in_addr_lo = 2'd0;
    tick();
    in_valid = 1'b0; in_load = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    chk("arst cnt", 32'(retire_cnt), 32'd0);
    chk("arst mis", 32'(err_misalign), 32'd0);
    chk("arst tmo", 32'(err_timeout), 32'd0);
    chk("arst wdata", wdata, 32'd0);
    chk("arst ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("post rst we", 32'(we), 32'd0);
    chk("post rst wdata", wdata, 32'd0);
    chk_cnt("post rst cnt");

    for (int i = 0; i < 16; i++) begin
      alu(5'd1, 32'(i + 1));
      tick();
      chk("wrap we", 32'(we), 32'd1);
      chk("wrap wdata", wdata, 32'(i + 1));
    end
    in_valid = 1'b0;
    chk("wrap cnt15", 32'(retire_cnt), 32'd15);
    tick();
    chk("wrap cnt0", 32'(retire_cnt), 32'd0);
    chk("wrap we off", 32'(we), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
